// File: rtl/lc3_pipe_ctrl_pkg.sv
// Shared LC3 pipeline constants: opcodes, data-memory access codes and
// the sequencer state type.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    localparam logic [1:0] MS_RD   = 2'd0;
    localparam logic [1:0] MS_IND  = 2'd1;
    localparam logic [1:0] MS_WR   = 2'd2;
    localparam logic [1:0] MS_IDLE = 2'd3;

    typedef enum logic [2:0] {
        S_RUN,
        S_MEM_IND,
        S_MEM_RD,
        S_MEM_WR,
        S_BR_WAIT
    } ctrl_state_t;

endpackage

// File: rtl/lc3_pipe_ctrl_op_class.sv
// Opcode classifier: flags memory, load, indirect and control-flow opcodes.
module lc3_op_class
    import lc3_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_mem,
    output logic       is_load,
    output logic       is_indirect,
    output logic       is_ctrl
);

    always_comb begin
        is_mem      = 1'b0;
        is_load     = 1'b0;
        is_indirect = 1'b0;
        is_ctrl     = 1'b0;
        case (opcode)
            OP_LD, OP_LDR: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            OP_LDI: begin
                is_mem      = 1'b1;
                is_load     = 1'b1;
                is_indirect = 1'b1;
            end
            OP_ST, OP_STR: is_mem = 1'b1;
            OP_STI: begin
                is_mem      = 1'b1;
                is_indirect = 1'b1;
            end
            OP_BR, OP_JMP: is_ctrl = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC3 four-stage pipeline sequencer: stage enables, memory stalls and
// branch resolution with a two-cycle fetch hold.
module lc3_pipe_ctrl
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  psr,
    output logic        enable_fetch,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic [1:0]  mem_state
);

    ctrl_state_t state;
    logic        v_d, v_e, v_w;
    logic        mem_done;
    logic        br_cnt;

    logic dec_mem, dec_load, dec_ind, dec_ctrl;
    logic exe_mem, exe_load, exe_ind, exe_ctrl;

    lc3_op_class u_dec_class (
        .opcode      (IR[15:12]),
        .is_mem      (dec_mem),
        .is_load     (dec_load),
        .is_indirect (dec_ind),
        .is_ctrl     (dec_ctrl)
    );

    lc3_op_class u_exe_class (
        .opcode      (IR_Exec[15:12]),
        .is_mem      (exe_mem),
        .is_load     (exe_load),
        .is_indirect (exe_ind),
        .is_ctrl     (exe_ctrl)
    );

    logic unused_ok;
    assign unused_ok = ^{IR[11:0], IR_Exec[8:0], dec_mem, dec_load, dec_ind, exe_ctrl};

    logic mem_pend, advance, br_cond;
    assign mem_pend = v_w & ~mem_done & exe_mem;
    assign advance  = complete_instr & ~mem_pend;
    assign br_cond  = (IR_Exec[15:12] == OP_JMP) | (|(IR_Exec[11:9] & psr));

    // Outputs are decoded from registered state plus live inputs; rst masks everything.
    always_comb begin
        enable_fetch     = 1'b0;
        enable_updatePC  = 1'b0;
        br_taken         = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        mem_state        = MS_IDLE;
        if (!rst) begin
            case (state)
                S_RUN: begin
                    enable_fetch = ~mem_pend;
                    if (advance) begin
                        enable_updatePC  = 1'b1;
                        enable_decode    = v_d;
                        enable_execute   = v_e;
                        enable_writeback = v_w & ~mem_done;
                    end
                end
                S_MEM_IND: mem_state = MS_IND;
                S_MEM_RD: begin
                    mem_state        = MS_RD;
                    enable_writeback = complete_data;
                end
                S_MEM_WR: mem_state = MS_WR;
                S_BR_WAIT: begin
                    if (br_cnt) begin
                        enable_execute   = 1'b1;
                        enable_writeback = v_w;
                    end else begin
                        enable_updatePC = 1'b1;
                        br_taken        = br_cond;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            v_d      <= 1'b0;
            v_e      <= 1'b0;
            v_w      <= 1'b0;
            mem_done <= 1'b0;
            br_cnt   <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_pend) begin
                        state <= exe_ind  ? S_MEM_IND :
                                 exe_load ? S_MEM_RD  : S_MEM_WR;
                    end else if (complete_instr) begin
                        mem_done <= 1'b0;
                        v_w      <= v_e;
                        // A control op leaving decode leaves a bubble behind it.
                        if (v_d && dec_ctrl) begin
                            state  <= S_BR_WAIT;
                            br_cnt <= 1'b1;
                            v_d    <= 1'b0;
                            v_e    <= 1'b1;
                        end else begin
                            v_d <= 1'b1;
                            v_e <= v_d;
                        end
                    end
                end
                S_MEM_IND: begin
                    if (complete_data)
                        state <= exe_load ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD, S_MEM_WR: begin
                    if (complete_data) begin
                        state    <= S_RUN;
                        mem_done <= 1'b1;
                    end
                end
                S_BR_WAIT: begin
                    if (br_cnt) begin
                        br_cnt <= 1'b0;
                    end else begin
                        state <= S_RUN;
                        v_w   <= v_e;
                        v_e   <= 1'b0;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule
